// File: rtl/dequ_fp_pkg.sv
// Shared float-format helpers for the dequantizer integer-to-float path.
package dequ_fp_pkg;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  // Exponent bias for an ew-bit exponent field.
  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // Packed {sign, exp, frac} width.
  function automatic int fp_width(input int ew, input int mw);
    return 1 + ew + mw;
  endfunction

  // LSB index of a lane inside a flat lane bus.
  function automatic int lane_lo(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/leading_one_detect.sv
// Leading-one detector: position of the highest set bit plus an all-zero flag.
module leading_one_detect #(
  parameter int WWIDTH = 32,
  parameter int PW     = (WWIDTH > 1) ? $clog2(WWIDTH) : 1
) (
  input  logic [WWIDTH-1:0] i_val,
  output logic [PW-1:0]     o_pos,
  output logic              o_zero
);

  // Scan upward; the last set bit seen is the most significant one.
  always_comb begin
    o_pos = '0;
    for (int i = 0; i < WWIDTH; i++)
      if (i_val[i]) o_pos = PW'(i);
  end

  assign o_zero = ~|i_val;

endmodule

// File: rtl/mantissa_exponent_pack_pipe.sv
// Three-stage multi-lane integer-to-float packer: capture/abs, leading-one
// detect, normalise/round/pack. Valid/ready with a full-throughput pipeline.
module mantissa_exponent_pack_pipe
  import dequ_fp_pkg::*;
#(
  parameter int NUM_LANES  = 4,
  parameter int WWIDTH     = 32,
  parameter int EXPLENGTH  = 8,
  parameter int MANTLENGTH = 23,
  parameter int SIGNED_IN  = 1
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  output logic                                         in_ready,
  input  logic [NUM_LANES*WWIDTH-1:0]                  in_data,
  input  logic [EXPLENGTH-1:0]                         in_step_exp,
  input  logic                                         in_round_mode,
  output logic                                         out_valid,
  input  logic                                         out_ready,
  output logic [NUM_LANES*(1+EXPLENGTH+MANTLENGTH)-1:0] out_data,
  output logic [NUM_LANES-1:0]                         out_ovf,
  output logic [NUM_LANES-1:0]                         out_unf
);

  localparam int FW  = fp_width(EXPLENGTH, MANTLENGTH);
  localparam int PW  = (WWIDTH > 1) ? $clog2(WWIDTH) : 1;
  localparam int EW2 = EXPLENGTH + 2;
  localparam logic signed [EW2-1:0] BIAS_S = EW2'(fp_bias(EXPLENGTH));
  localparam logic signed [EW2-1:0] EMAX   = EW2'((1 << EXPLENGTH) - 1);
  localparam logic signed [EW2-1:0] EZERO  = '0;

  // Pipeline control: a stage loads when empty or when its successor moves.
  logic [3:1] r_vld;
  logic       w_ld1, w_ld2, w_ld3;

  assign w_ld3     = out_ready | ~r_vld[3];
  assign w_ld2     = w_ld3 | ~r_vld[2];
  assign w_ld1     = w_ld2 | ~r_vld[1];
  assign in_ready  = w_ld1;
  assign out_valid = r_vld[3];

  // S1 capture
  logic [NUM_LANES-1:0]             w1_sign, r1_sign;
  logic [NUM_LANES-1:0][WWIDTH-1:0] w1_mag, r1_mag;
  logic [EXPLENGTH-1:0]             r1_exp;
  logic                             r1_rnd;
  // S2 detect
  logic [NUM_LANES-1:0]             w2_zero, r2_zero, r2_sign;
  logic [NUM_LANES-1:0][PW-1:0]     w2_pos, r2_pos;
  logic [NUM_LANES-1:0][WWIDTH-1:0] r2_mag;
  logic [EXPLENGTH-1:0]             r2_exp;
  logic                             r2_rnd;
  // S3 pack
  logic [NUM_LANES*FW-1:0]          w3_data;
  logic [NUM_LANES-1:0]             w3_ovf, w3_unf;

  // Stage valid shift register; reset drops every in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      if (w_ld1) r_vld[1] <= in_valid;
      if (w_ld2) r_vld[2] <= r_vld[1];
      if (w_ld3) r_vld[3] <= r_vld[2];
    end
  end

  // Stage data registers; only load on a real transfer into the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_sign <= '0; r1_mag <= '0; r1_exp <= '0; r1_rnd <= RND_TRUNC;
      r2_sign <= '0; r2_mag <= '0; r2_pos <= '0; r2_zero <= '0;
      r2_exp  <= '0; r2_rnd <= RND_TRUNC;
      out_data <= '0; out_ovf <= '0; out_unf <= '0;
    end else begin
      if (w_ld1 && in_valid) begin
        r1_sign <= w1_sign;
        r1_mag  <= w1_mag;
        r1_exp  <= in_step_exp;
        r1_rnd  <= in_round_mode;
      end
      if (w_ld2 && r_vld[1]) begin
        r2_sign <= r1_sign;
        r2_mag  <= r1_mag;
        r2_pos  <= w2_pos;
        r2_zero <= w2_zero;
        r2_exp  <= r1_exp;
        r2_rnd  <= r1_rnd;
      end
      if (w_ld3 && r_vld[2]) begin
        out_data <= w3_data;
        out_ovf  <= w3_ovf;
        out_unf  <= w3_unf;
      end
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [WWIDTH-1:0] w_raw;

    assign w_raw      = in_data[lane_lo(l, WWIDTH) +: WWIDTH];
    // Magnitude fits WWIDTH bits unsigned, including the most-negative value.
    assign w1_sign[l] = (SIGNED_IN != 0) ? w_raw[WWIDTH-1] : 1'b0;
    assign w1_mag[l]  = w1_sign[l] ? (~w_raw + WWIDTH'(1)) : w_raw;

    leading_one_detect #(.WWIDTH(WWIDTH), .PW(PW)) u_lod (
      .i_val  (r1_mag[l]),
      .o_pos  (w2_pos[l]),
      .o_zero (w2_zero[l])
    );

    logic [PW-1:0]                  w_sh;
    logic [WWIDTH+MANTLENGTH-2:0]   w_ext;
    logic [MANTLENGTH-1:0]          w_frac;
    logic                           w_guard, w_sticky, w_inc;
    logic [MANTLENGTH:0]            w_frac_r;
    logic signed [EW2-1:0]          w_e;
    logic [FW-1:0]                  w_pack;
    logic                           w_ovf, w_unf;

    // Normalise so the leading one falls off the top (hidden bit), then
    // round the fraction and clamp the exponent to inf / flushed zero.
    always_comb begin
      w_sh     = PW'(WWIDTH - 1) - r2_pos[l];
      w_ext    = (WWIDTH+MANTLENGTH-1)'({r2_mag[l], {MANTLENGTH{1'b0}}} << w_sh);
      w_frac   = w_ext[WWIDTH+MANTLENGTH-2 -: MANTLENGTH];
      w_guard  = w_ext[WWIDTH-2];
      w_sticky = |w_ext[WWIDTH-3:0];
      w_inc    = (r2_rnd == RND_RNE) & w_guard & (w_sticky | w_frac[0]);
      w_frac_r = {1'b0, w_frac} + (MANTLENGTH+1)'(w_inc);
      w_e      = BIAS_S + EW2'(signed'(r2_exp)) + EW2'(r2_pos[l])
               + EW2'(w_frac_r[MANTLENGTH]);
      w_pack   = '0;
      w_ovf    = 1'b0;
      w_unf    = 1'b0;
      if (r2_zero[l]) begin
        w_pack = '0;
      end else if (w_e >= EMAX) begin
        w_pack = {r2_sign[l], {EXPLENGTH{1'b1}}, {MANTLENGTH{1'b0}}};
        w_ovf  = 1'b1;
      end else if (w_e <= EZERO) begin
        w_pack = {r2_sign[l], {(FW-1){1'b0}}};
        w_unf  = 1'b1;
      end else begin
        w_pack = {r2_sign[l], w_e[EXPLENGTH-1:0], w_frac_r[MANTLENGTH-1:0]};
      end
    end

    assign w3_data[lane_lo(l, FW) +: FW] = w_pack;
    assign w3_ovf[l] = w_ovf;
    assign w3_unf[l] = w_unf;
  end

endmodule

// File: tb/tb_mantissa_exponent_pack_pipe.sv
// Bench for mantissa_exponent_pack_pipe: directed spec vectors, backpressure,
// reset flush and randomized traffic checked against an arithmetic model.
module tb_mantissa_exponent_pack_pipe;

  localparam int NL = 4;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   ovf;
    logic [3:0]   unf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic [7:0]   in_step_exp;
  logic         in_round_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [3:0]   out_ovf;
  logic [3:0]   out_unf;

  logic or_man, or_rand, bp_rand;
  assign out_ready = bp_rand ? or_rand : or_man;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q_exp[$];

  mantissa_exponent_pack_pipe #(
    .NUM_LANES(NL), .WWIDTH(32), .EXPLENGTH(8), .MANTLENGTH(23), .SIGNED_IN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_step_exp(in_step_exp), .in_round_mode(in_round_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  // Reference: real-number view -- value = m * 2^step, written as q * 2^(e-bias)
  // with q a 24-bit significand obtained by integer division and remainder.
  function automatic void model_lane(input logic [31:0] v, input logic [7:0] step,
                                     input bit rnd, output logic [31:0] w,
                                     output bit ovf, output bit unf);
    bit     s = v[31];
    longint m = s ? (64'h1_0000_0000 - longint'(v)) : longint'(v);
    longint q, rem, half;
    int     p, e;
    ovf = 0; unf = 0; w = '0;
    if (m == 0) return;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p >= 23) begin
      q   = m >> (p - 23);
      rem = m - (q << (p - 23));
      if (rnd && p >= 24) begin
        half = longint'(1) << (p - 24);
        if (rem > half || (rem == half && q[0])) q++;
      end
    end else begin
      q = m << (23 - p);
    end
    e = 127 + int'($signed(step)) + p;
    if (q == (longint'(1) << 24)) begin q = q >> 1; e++; end
    if (e >= 255)    begin w = {s, 8'hFF, 23'h0}; ovf = 1; end
    else if (e <= 0) begin w = {s, 31'h0};        unf = 1; end
    else             w = {s, e[7:0], q[22:0]};
  endfunction

  function automatic exp_t model(input logic [127:0] d, input logic [7:0] step, input bit rnd);
    exp_t r;
    logic [31:0] w;
    bit o, u;
    for (int l = 0; l < NL; l++) begin
      model_lane(d[l*32 +: 32], step, rnd, w, o, u);
      r.d[l*32 +: 32] = w;
      r.ovf[l] = o;
      r.unf[l] = u;
    end
    return r;
  endfunction

  // Drive one transaction and wait for acceptance; in_valid stays high so
  // consecutive calls stream back-to-back.
  task automatic send(input logic [127:0] d, input logic [7:0] st, input bit rnd, input exp_t e);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_step_exp = st; in_round_mode = rnd;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 300) begin
        n_tests++; n_fail++;
        $display("FAIL send_timeout obs in_ready=0 exp in_ready=1");
        in_valid = 1'b0;
        return;
      end
    end
    q_exp.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic send_dir(input logic [127:0] d, input logic [7:0] st, input bit rnd,
                          input logic [127:0] xd, input logic [3:0] xo, input logic [3:0] xu);
    exp_t e;
    e.d = xd; e.ovf = xo; e.unf = xu;
    send(d, st, rnd, e);
  endtask

  task automatic send_mod(input logic [127:0] d, input logic [7:0] st, input bit rnd);
    send(d, st, rnd, model(d, st, rnd));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [127:0] rand_data();
    logic [127:0] d;
    logic [31:0]  v;
    for (int l = 0; l < NL; l++) begin
      v = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) v = -v;
      if ($urandom_range(0, 15) == 0) v = 32'h8000_0000;
      d[l*32 +: 32] = v;
    end
    return d;
  endfunction

  function automatic logic [7:0] rand_step();
    if ($urandom_range(0, 5) == 0) return 8'($urandom);
    return 8'($urandom_range(0, 40) - 20);
  endfunction

  // Random backpressure source.
  always @(posedge clk) or_rand <= ($urandom_range(0, 2) != 0);

  // Output monitor: scoreboard on every transfer, hold check while stalled.
  initial begin
    bit           prev_stall = 0;
    logic [127:0] pd;
    logic [3:0]   po, pu;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          n_tests++;
          assert (out_valid === 1'b1 && out_data === pd && out_ovf === po && out_unf === pu)
          else begin
            n_fail++;
            $error("FAIL hold obs=%h/%b/%b exp=%h/%b/%b", out_data, out_ovf, out_unf, pd, po, pu);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          n_tests++;
          if (q_exp.size() == 0) begin
            n_fail++;
            $error("FAIL unexpected_out obs=%h exp=none", out_data);
          end else begin
            e = q_exp.pop_front();
            assert (out_data === e.d && out_ovf === e.ovf && out_unf === e.unf)
            else begin
              n_fail++;
              $error("FAIL data obs=%h ovf=%b unf=%b exp=%h ovf=%b unf=%b",
                     out_data, out_ovf, out_unf, e.d, e.ovf, e.unf);
            end
          end
        end
        prev_stall = out_valid & ~out_ready;
        pd = out_data; po = out_ovf; pu = out_unf;
      end
    end
  end

  initial begin
    logic [127:0] bd [10];
    logic [7:0]   bs [10];
    bit           br [10];
    int           idx, wait_n;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_step_exp = '0;
    in_round_mode = 1'b1; or_man = 1'b1; bp_rand = 1'b0;
    #12;
    n_tests++;
    assert (out_valid === 1'b0 && in_ready === 1'b1 && out_data === '0 &&
            out_ovf === '0 && out_unf === '0)
    else begin
      n_fail++;
      $error("FAIL reset obs v=%b rdy=%b d=%h exp v=0 rdy=1 d=0", out_valid, in_ready, out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    cyc(2);

    // Basic conversion plus latency.
    send_dir({32'd0, 32'd0, 32'd6, 32'd1}, 8'd0, 1'b1,
             {32'h0, 32'h0, 32'h40C00000, 32'h3F800000}, 4'b0, 4'b0);
    in_valid = 1'b0;
    cyc(1);
    n_tests++;
    assert (out_valid === 1'b0) else begin
      n_fail++; $error("FAIL latency_early obs=%b exp=0", out_valid);
    end
    cyc(1);
    n_tests++;
    assert (out_valid === 1'b1) else begin
      n_fail++; $error("FAIL latency obs=%b exp=1", out_valid);
    end
    cyc(2);

    // Back-to-back directed vectors.
    send_dir({32'd0, 32'd0, 32'd6, 32'd1}, 8'd2, 1'b1,
             {32'h0, 32'h0, 32'h41C00000, 32'h40800000}, 4'b0, 4'b0);
    send_dir({32'h01000001, 32'h0, 32'h80000000, 32'hFFFFFFFF}, 8'd0, 1'b1,
             {32'h4B800000, 32'h0, 32'hCF000000, 32'hBF800000}, 4'b0, 4'b0);
    send_dir({32'h0, 32'h0, 32'h01FFFFFF, 32'h01000003}, 8'd0, 1'b1,
             {32'h0, 32'h0, 32'h4C000000, 32'h4B800002}, 4'b0, 4'b0);
    send_dir({32'h0, 32'h01FFFFFF, 32'h01000003, 32'h01000001}, 8'd0, 1'b0,
             {32'h0, 32'h4BFFFFFF, 32'h4B800001, 32'h4B800000}, 4'b0, 4'b0);
    send_dir({32'h0, 32'h0, 32'd1, 32'd2}, 8'h7F, 1'b1,
             {32'h0, 32'h0, 32'h7F000000, 32'h7F800000}, 4'b0001, 4'b0);
    send_dir({32'h0, 32'hFFFFFFFF, 32'd2, 32'd1}, 8'h81, 1'b1,
             {32'h0, 32'h80000000, 32'h00800000, 32'h0}, 4'b0, 4'b0101);
    in_valid = 1'b0;
    cyc(6);

    // Backpressure: 10 transactions, output stalled for 5 cycles.
    for (int i = 0; i < 10; i++) begin
      bd[i] = rand_data(); bs[i] = rand_step(); br[i] = $urandom_range(0, 1);
    end
    or_man = 1'b0; idx = 0;
    in_valid = 1'b1; in_data = bd[0]; in_step_exp = bs[0]; in_round_mode = br[0];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (in_ready) begin q_exp.push_back(model(bd[idx], bs[idx], br[idx])); idx++; end
      @(posedge clk); #1;
      in_data = bd[idx]; in_step_exp = bs[idx]; in_round_mode = br[idx];
    end
    n_tests++;
    assert (idx === 3 && in_ready === 1'b0) else begin
      n_fail++; $error("FAIL bp_accept obs=%0d rdy=%b exp=3 rdy=0", idx, in_ready);
    end
    or_man = 1'b1;
    while (idx < 10) begin send_mod(bd[idx], bs[idx], br[idx]); idx++; end
    in_valid = 1'b0;
    cyc(6);
    n_tests++;
    assert (q_exp.size() === 0) else begin
      n_fail++; $error("FAIL bp_drain obs=%0d exp=0", q_exp.size());
    end

    // Reset with two transactions in flight.
    or_man = 1'b0;
    send_mod(rand_data(), 8'd0, 1'b1);
    send_mod(rand_data(), 8'd0, 1'b1);
    in_valid = 1'b0;
    cyc(1);
    n_tests++;
    assert (out_valid === 1'b1) else begin
      n_fail++; $error("FAIL rst_pre obs=%b exp=1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    q_exp.delete();
    n_tests++;
    assert (out_valid === 1'b0 && in_ready === 1'b1) else begin
      n_fail++; $error("FAIL rst_flush obs v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
    end
    @(negedge clk); rst_n = 1'b1; or_man = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc(1);
      n_tests++;
      assert (out_valid === 1'b0 && in_ready === 1'b1) else begin
        n_fail++; $error("FAIL rst_stale obs v=%b rdy=%b exp v=0 rdy=1", out_valid, in_ready);
      end
    end

    // Randomized traffic with random backpressure and idle gaps.
    bp_rand = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send_mod(rand_data(), rand_step(), $urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) begin in_valid = 1'b0; cyc($urandom_range(1, 3)); end
    end
    in_valid = 1'b0;
    bp_rand = 1'b0;
    wait_n = 0;
    while (q_exp.size() != 0 && wait_n < 50) begin cyc(1); wait_n++; end
    cyc(2);
    n_tests++;
    assert (q_exp.size() === 0 && out_valid === 1'b0) else begin
      n_fail++; $error("FAIL final_drain obs=%0d exp=0", q_exp.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
